conv2d_relu_engine: RTL and testbench

Sequential, resource-shared 2-D convolution layer with optional fused ReLU. It is the clocked replacement for the combinational conv/ReLU stages in the CNN datapath, between the input image buffer and the maxpool stage. It computes every output pixel with a single multiply-accumulate unit, then requantizes and saturates the result into a registered output array.

---
 rtl/conv2d_relu_engine_pkg.sv | 40 ++++
 rtl/conv2d_relu_engine_sat_relu.sv | 25 ++
 rtl/conv2d_relu_engine.sv | 192 +++++++++++++++++++
 tb/tb_conv2d_relu_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_relu_engine_pkg.sv
// conv_pkg: state encoding and sizing/saturation helpers shared by
// conv2d_relu_engine and conv_sat_relu.
package conv_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_WRITE,
      S_DONE
   } conv_state_e;

   function automatic int unsigned out_dim(input int unsigned in_sz,
                                           input int unsigned pad,
                                           input int unsigned k,
                                           input int unsigned stride);
      return (in_sz + 2 * pad - k) / stride + 1;
   endfunction

   function automatic int unsigned acc_width(input int unsigned data_size,
                                             input int unsigned taps);
      return 2 * data_size + $clog2(taps);
   endfunction

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int unsigned width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/conv2d_relu_engine_sat_relu.sv
// conv_sat_relu: accumulator requantization (arithmetic shift, signed
// saturation, ReLU clamp when CONV2D_RELU_EN is defined).
module conv_sat_relu
   import conv_pkg::*;
#(
   parameter int unsigned data_size = 16,
   parameter int unsigned frac_bits = 0,
   parameter int unsigned acc_w     = 36
) (
   input  logic signed [acc_w-1:0]     acc,
   output logic signed [data_size-1:0] y
);

   logic signed [acc_w-1:0] shifted;

   always_comb begin
      shifted = acc >>> frac_bits;
      y       = data_size'(sat_signed(64'(shifted), data_size));
`ifdef CONV2D_RELU_EN
      // Sign of the shifted value equals the sign of the saturated value.
      if (shifted[acc_w-1]) y = '0;
`endif
   end

endmodule

// File: rtl/conv2d_relu_engine.sv
// conv2d_relu_engine: single-MAC sequential 2-D convolution with registered
// output array. Define CONV2D_RELU_EN to clamp negative results to zero.
module conv2d_relu_engine
   import conv_pkg::*;
#(
   parameter int unsigned in_channels  = 1,
   parameter int unsigned out_channels = 1,
   parameter int unsigned kern_rows    = 3,
   parameter int unsigned kern_cols    = 3,
   parameter int unsigned stride_rows  = 1,
   parameter int unsigned stride_cols  = 1,
   parameter int unsigned pad_rows     = 0,
   parameter int unsigned pad_cols     = 0,
   parameter int unsigned in_rows      = 4,
   parameter int unsigned in_cols      = 4,
   parameter int unsigned data_size    = 16,
   parameter int unsigned frac_bits    = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic signed [data_size-1:0] in [in_channels][in_rows][in_cols],
   input  logic                        kern_we,
   input  logic [idx_w(out_channels*in_channels*kern_rows*kern_cols)-1:0] kern_addr,
   input  logic signed [data_size-1:0] kern_data,
   output logic                        busy,
   output logic                        done,
   output logic signed [data_size-1:0] out [out_channels]
                                            [out_dim(in_rows, pad_rows, kern_rows, stride_rows)]
                                            [out_dim(in_cols, pad_cols, kern_cols, stride_cols)]
);

   localparam int unsigned TAPS     = in_channels * kern_rows * kern_cols;
   localparam int unsigned KN       = out_channels * TAPS;
   localparam int unsigned OUT_ROWS = out_dim(in_rows, pad_rows, kern_rows, stride_rows);
   localparam int unsigned OUT_COLS = out_dim(in_cols, pad_cols, kern_cols, stride_cols);
   localparam int unsigned ACC_W    = acc_width(data_size, TAPS);
   localparam int unsigned PW       = 2 * data_size;
   localparam int unsigned KAW      = idx_w(KN);
   localparam int unsigned ICW      = idx_w(in_channels);
   localparam int unsigned KRW      = idx_w(kern_rows);
   localparam int unsigned KCW      = idx_w(kern_cols);
   localparam int unsigned OCW      = idx_w(out_channels);
   localparam int unsigned ORW      = idx_w(OUT_ROWS);
   localparam int unsigned OLW      = idx_w(OUT_COLS);
   localparam int unsigned IRW      = idx_w(in_rows);
   localparam int unsigned ILW      = idx_w(in_cols);

   conv_state_e state_q, state_d;
   logic [ICW-1:0] ic_q, ic_d;
   logic [KRW-1:0] kr_q, kr_d;
   logic [KCW-1:0] kc_q, kc_d;
   logic [OCW-1:0] oc_q, oc_d;
   logic [ORW-1:0] orow_q, orow_d;
   logic [OLW-1:0] ocol_q, ocol_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   logic signed [data_size-1:0] kernels [KN];
   logic signed [data_size-1:0] out_q [out_channels][OUT_ROWS][OUT_COLS];

   logic signed [data_size-1:0] px;
   logic signed [data_size-1:0] kw;
   logic signed [data_size-1:0] res;
   logic signed [PW-1:0]        prod;
   logic                        tap_first;
   logic                        tap_last;
   logic                        pix_last;
   int                          iy;
   int                          ix;
   int                          kidx;

   assign busy = (state_q == S_MAC) || (state_q == S_WRITE);
   assign done = (state_q == S_DONE);
   assign out  = out_q;

   // Tap operand fetch: padding positions read zero but still cost a cycle.
   always_comb begin
      iy   = int'(orow_q) * int'(stride_rows) + int'(kr_q) - int'(pad_rows);
      ix   = int'(ocol_q) * int'(stride_cols) + int'(kc_q) - int'(pad_cols);
      kidx = ((int'(oc_q) * int'(in_channels) + int'(ic_q)) * int'(kern_rows)
              + int'(kr_q)) * int'(kern_cols) + int'(kc_q);
      px   = '0;
      if (iy >= 0 && iy < int'(in_rows) && ix >= 0 && ix < int'(in_cols))
         px = in[ic_q][IRW'(iy)][ILW'(ix)];
      kw   = kernels[KAW'(kidx)];
      prod = PW'(px) * PW'(kw);
   end

   always_comb begin
      tap_first = (ic_q == '0) && (kr_q == '0) && (kc_q == '0);
      tap_last  = (ic_q == ICW'(in_channels - 1)) && (kr_q == KRW'(kern_rows - 1))
                  && (kc_q == KCW'(kern_cols - 1));
      pix_last  = (oc_q == OCW'(out_channels - 1)) && (orow_q == ORW'(OUT_ROWS - 1))
                  && (ocol_q == OLW'(OUT_COLS - 1));
   end

   always_comb begin
      state_d = state_q;
      ic_d    = ic_q;
      kr_d    = kr_q;
      kc_d    = kc_q;
      oc_d    = oc_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = start ? S_MAC : S_IDLE;
            if (start) begin
               ic_d   = '0;
               kr_d   = '0;
               kc_d   = '0;
               oc_d   = '0;
               orow_d = '0;
               ocol_d = '0;
            end
         end
         S_MAC: begin
            acc_d = (tap_first ? '0 : acc_q) + ACC_W'(prod);
            if (kc_q == KCW'(kern_cols - 1)) begin
               kc_d = '0;
               if (kr_q == KRW'(kern_rows - 1)) begin
                  kr_d = '0;
                  ic_d = (ic_q == ICW'(in_channels - 1)) ? '0 : ic_q + ICW'(1);
               end else begin
                  kr_d = kr_q + KRW'(1);
               end
            end else begin
               kc_d = kc_q + KCW'(1);
            end
            if (tap_last) state_d = S_WRITE;
         end
         S_WRITE: begin
            state_d = pix_last ? S_DONE : S_MAC;
            if (ocol_q == OLW'(OUT_COLS - 1)) begin
               ocol_d = '0;
               if (orow_q == ORW'(OUT_ROWS - 1)) begin
                  orow_d = '0;
                  oc_d   = (oc_q == OCW'(out_channels - 1)) ? '0 : oc_q + OCW'(1);
               end else begin
                  orow_d = orow_q + ORW'(1);
               end
            end else begin
               ocol_d = ocol_q + OLW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ic_q    <= '0;
         kr_q    <= '0;
         kc_q    <= '0;
         oc_q    <= '0;
         orow_q  <= '0;
         ocol_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         ic_q    <= ic_d;
         kr_q    <= kr_d;
         kc_q    <= kc_d;
         oc_q    <= oc_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         acc_q   <= acc_d;
      end
   end

   // Kernel store survives reset so a loaded kernel outlives an aborted run.
   always_ff @(posedge clk) begin
      if (kern_we && !busy) kernels[kern_addr] <= kern_data;
   end

   always_ff @(posedge clk) begin
      if (rst) out_q <= '{default: '0};
      else if (state_q == S_WRITE) out_q[oc_q][orow_q][ocol_q] <= res;
   end

   conv_sat_relu #(
      .data_size(data_size),
      .frac_bits(frac_bits),
      .acc_w    (ACC_W)
   ) u_sat (
      .acc(acc_q),
      .y  (res)
   );

endmodule

// File: tb/tb_conv2d_relu_engine.sv
// Self-checking bench for conv2d_relu_engine: default 3x3 instance plus a
// padded/strided 1x1 instance, compared against a loop-level convolution model.
module tb_conv2d_relu_engine;

   typedef struct {
      int nic, nir, nicl, nkr, nkc, sr, sc, pr, pc, dw, fb;
   } cfg_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: defaults (1ch, 3x3 kernel, 4x4 in, 2x2 out, 16-bit).
   logic               a_start = 1'b0;
   logic signed [15:0] a_in [1][4][4];
   logic               a_kern_we = 1'b0;
   logic [3:0]         a_kern_addr = '0;
   logic signed [15:0] a_kern_data = '0;
   logic               a_busy, a_done;
   logic signed [15:0] a_out [1][2][2];

   // Instance P: 8-bit, 1x1 kernel, pad 1, stride 2, frac_bits 1 -> 3x3 out.
   logic               p_start = 1'b0;
   logic signed [7:0]  p_in [1][4][4];
   logic               p_kern_we = 1'b0;
   logic [0:0]         p_kern_addr = '0;
   logic signed [7:0]  p_kern_data = '0;
   logic               p_busy, p_done;
   logic signed [7:0]  p_out [1][3][3];

   conv2d_relu_engine dut (
      .clk(clk), .rst(rst), .start(a_start), .in(a_in), .kern_we(a_kern_we),
      .kern_addr(a_kern_addr), .kern_data(a_kern_data), .busy(a_busy),
      .done(a_done), .out(a_out)
   );

   conv2d_relu_engine #(
      .in_channels(1), .out_channels(1), .kern_rows(1), .kern_cols(1),
      .stride_rows(2), .stride_cols(2), .pad_rows(1), .pad_cols(1),
      .in_rows(4), .in_cols(4), .data_size(8), .frac_bits(1)
   ) dutp (
      .clk(clk), .rst(rst), .start(p_start), .in(p_in), .kern_we(p_kern_we),
      .kern_addr(p_kern_addr), .kern_data(p_kern_data), .busy(p_busy),
      .done(p_done), .out(p_out)
   );

   int   vectors = 0;
   int   miscompares = 0;
   cfg_t ca, cp;
   int   a_img_m[];
   int   a_kern_m[];
   int   p_img_m[];
   int   p_kern_m[];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Direct convolution definition: sum over taps, zero outside the image,
   // floor shift, clamp to the signed word range, optional ReLU.
   function automatic longint model_pix(input cfg_t g, input int img[], input int kern[],
                                        input int oc, input int r, input int c);
      longint acc = 0;
      longint hi, lo;
      for (int ic = 0; ic < g.nic; ic++)
         for (int kr = 0; kr < g.nkr; kr++)
            for (int kc = 0; kc < g.nkc; kc++) begin
               int y, x;
               y = r * g.sr + kr - g.pr;
               x = c * g.sc + kc - g.pc;
               if (y >= 0 && y < g.nir && x >= 0 && x < g.nicl)
                  acc += longint'(img[(ic * g.nir + y) * g.nicl + x])
                         * longint'(kern[((oc * g.nic + ic) * g.nkr + kr) * g.nkc + kc]);
            end
      acc = acc >>> g.fb;
      hi  = (longint'(1) << (g.dw - 1)) - 1;
      lo  = -hi - 1;
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
`ifdef CONV2D_RELU_EN
      if (acc < 0) acc = 0;
`endif
      return acc;
   endfunction

   task automatic load_a;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) a_in[0][r][c] = 16'(a_img_m[r * 4 + c]);
      for (int i = 0; i < 9; i++) begin
         a_kern_we = 1'b1; a_kern_addr = 4'(i); a_kern_data = 16'(a_kern_m[i]);
         tick;
      end
      a_kern_we = 1'b0;
   endtask

   task automatic load_p;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) p_in[0][r][c] = 8'(p_img_m[r * 4 + c]);
      p_kern_we = 1'b1; p_kern_addr = 1'b0; p_kern_data = 8'(p_kern_m[0]);
      tick;
      p_kern_we = 1'b0;
   endtask

   task automatic check_a(input string tag);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            chk($sformatf("%s_a[%0d][%0d]", tag, r, c), a_out[0][r][c],
                model_pix(ca, a_img_m, a_kern_m, 0, r, c));
   endtask

   task automatic check_p(input string tag);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            chk($sformatf("%s_p[%0d][%0d]", tag, r, c), p_out[0][r][c],
                model_pix(cp, p_img_m, p_kern_m, 0, r, c));
   endtask

   // Start A at edge 0, optionally poke start+kern_we while busy, and time done.
   task automatic run_a(input string tag, input int poke_cyc, input bit wr_start);
      int cyc;
      bit busy_ok;
      a_start = 1'b1;
      if (wr_start) begin
         a_kern_we = 1'b1; a_kern_addr = 4'd8; a_kern_data = 16'(a_kern_m[8]);
      end
      tick;
      a_start = 1'b0; a_kern_we = 1'b0;
      cyc = 1; busy_ok = 1'b1;
      while (a_done !== 1'b1 && cyc < 200) begin
         if (a_busy !== 1'b1) busy_ok = 1'b0;
         if (cyc == poke_cyc) begin
            a_start = 1'b1; a_kern_we = 1'b1; a_kern_addr = 4'd0; a_kern_data = 16'sd7;
         end
         tick;
         a_start = 1'b0; a_kern_we = 1'b0;
         cyc++;
      end
      chk({tag, "_done_cycle"}, cyc, 41);
      chk({tag, "_busy_during_run"}, busy_ok, 1);
      chk({tag, "_busy_at_done"}, a_busy, 0);
      tick;
      chk({tag, "_done_pulse"}, a_done, 0);
   endtask

   task automatic run_p(input string tag);
      int cyc;
      p_start = 1'b1;
      tick;
      p_start = 1'b0;
      cyc = 1;
      while (p_done !== 1'b1 && cyc < 200) begin
         tick;
         cyc++;
      end
      chk({tag, "_done_cycle"}, cyc, 19);
      chk({tag, "_busy_at_done"}, p_busy, 0);
      tick;
   endtask

   initial begin
      int seen_done;
      ca = '{1, 4, 4, 3, 3, 1, 1, 0, 0, 16, 0};
      cp = '{1, 4, 4, 1, 1, 2, 2, 1, 1, 8, 1};
      a_img_m = new[16]; a_kern_m = new[9];
      p_img_m = new[16]; p_kern_m = new[1];
      for (int i = 0; i < 16; i++) begin
         a_in[0][i / 4][i % 4] = '0;
         p_in[0][i / 4][i % 4] = '0;
      end

      // Reset state
      rst = 1'b1;
      repeat (3) tick;
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_done", a_done, 0);
      chk("rst_p_busy", p_busy, 0);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) chk("rst_a_out", a_out[0][r][c], 0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) chk("rst_p_out", p_out[0][r][c], 0);
      rst = 1'b0;
      tick;

      // Ramp image, all-ones kernel
      for (int i = 0; i < 16; i++) a_img_m[i] = i + 1;
      for (int i = 0; i < 9; i++) a_kern_m[i] = 1;
      load_a;
      run_a("ones", -1, 1'b0);
      chk("ones_out00", a_out[0][0][0], 54);
      chk("ones_out01", a_out[0][0][1], 63);
      chk("ones_out10", a_out[0][1][0], 90);
      chk("ones_out11", a_out[0][1][1], 99);

      // All -1 kernel
      for (int i = 0; i < 9; i++) a_kern_m[i] = -1;
      load_a;
      run_a("neg", -1, 1'b0);
`ifdef CONV2D_RELU_EN
      chk("neg_out11", a_out[0][1][1], 0);
`else
      chk("neg_out11", a_out[0][1][1], -99);
`endif
      check_a("neg");

      // Saturation both directions
      for (int i = 0; i < 16; i++) a_img_m[i] = 32767;
      for (int i = 0; i < 9; i++) a_kern_m[i] = 32767;
      load_a;
      run_a("satp", -1, 1'b0);
      chk("satp_out00", a_out[0][0][0], 32767);
      check_a("satp");
      for (int i = 0; i < 9; i++) a_kern_m[i] = -32767;
      load_a;
      run_a("satn", -1, 1'b0);
      check_a("satn");

      // start and kern_we while busy are both ignored
      for (int i = 0; i < 16; i++) a_img_m[i] = i + 1;
      for (int i = 0; i < 9; i++) a_kern_m[i] = 1;
      load_a;
      run_a("poke", 5, 1'b0);
      check_a("poke");
      run_a("poke_rerun", -1, 1'b0);
      check_a("poke_rerun");

      // kern_we together with start in IDLE: write lands before the run
      a_kern_m[8] = 3;
      run_a("wrstart", -1, 1'b1);
      check_a("wrstart");

      // Synchronous reset mid-run
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
      repeat (19) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst_busy", a_busy, 0);
      chk("midrst_done", a_done, 0);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) chk("midrst_out", a_out[0][r][c], 0);
      seen_done = 0;
      repeat (30) begin
         if (a_done === 1'b1) seen_done++;
         tick;
      end
      chk("midrst_no_done", seen_done, 0);
      run_a("after_rst", -1, 1'b0);
      check_a("after_rst");

      // Randomized images and kernels, small and full range
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 16; i++)
            a_img_m[i] = (t < 3) ? int'($urandom_range(0, 40)) - 20
                                 : int'($urandom_range(0, 65535)) - 32768;
         for (int i = 0; i < 9; i++)
            a_kern_m[i] = (t < 3) ? int'($urandom_range(0, 40)) - 20
                                  : int'($urandom_range(0, 65535)) - 32768;
         load_a;
         run_a($sformatf("rnd%0d", t), -1, 1'b0);
         check_a($sformatf("rnd%0d", t));
      end

      // Padded, strided instance: ramp image, kernel 2 with frac_bits 1
      for (int i = 0; i < 16; i++) p_img_m[i] = i + 1;
      p_kern_m[0] = 2;
      load_p;
      run_p("pad");
      chk("pad_out00", p_out[0][0][0], 0);
      chk("pad_out11", p_out[0][1][1], 6);
      chk("pad_out12", p_out[0][1][2], 8);
      chk("pad_out22", p_out[0][2][2], 16);
      check_p("pad");

      for (int i = 0; i < 16; i++) p_img_m[i] = 127;
      p_kern_m[0] = 127;
      load_p;
      run_p("psatp");
      chk("psatp_out11", p_out[0][1][1], 127);
      check_p("psatp");
      p_kern_m[0] = -127;
      load_p;
      run_p("psatn");
      check_p("psatn");

      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 16; i++) p_img_m[i] = int'($urandom_range(0, 255)) - 128;
         p_kern_m[0] = (t < 2) ? int'($urandom_range(0, 6)) - 3
                               : int'($urandom_range(0, 255)) - 128;
         load_p;
         run_p($sformatf("prnd%0d", t));
         check_p($sformatf("prnd%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
